counter_monitor: RTL and testbench
==================================

COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter: N, default 8, width of the counter being monitored.
REQ-002 Parameter: CW, default 16, width of the mismatch and check counters.
REQ-003 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 Port: arm  input  1  high enables checking; low returns the monitor to IDLE.
REQ-006 Port: load  input  1  load command observed at the counter's input.
REQ-007 Port: enable  input  1  count-enable command observed at the counter's input.
REQ-008 Port: dec  input  1  direction observed at the counter's input: 1 = down, 0 = up.
REQ-009 Port: load_value  input  N  load operand observed at the counter's input.
REQ-010 Port: counterN  input  N  registered counter output under observation.
REQ-011 Port: pass  output  1  high while in CHECK and no mismatch has been seen since arming.
REQ-012 Port: error  output  1  sticky; high while in FAIL.
REQ-013 Port: error_code  output  3  class of the first mismatch since arming.
REQ-014 Port: expected  output  N  current model (predicted) counter value.
REQ-015 Port: fail_observed  output  N  counterN value captured at the first mismatch.
REQ-016 Port: fail_expected  output  N  model value captured at the first mismatch.
REQ-017 Port: mismatch_count  output  CW  number of mismatches since arming; saturates at all-ones.
REQ-018 Port: check_count  output  CW  number of compare cycles since arming; saturates at all-ones.

Function
REQ-019 The model next value SHALL be computed as f(v) = load ? load_value : enable ? (dec ? v-1 : v+1) : v, modulo 2^N.
REQ-020 Priority SHALL be load over enable, and enable over hold; dec SHALL be ignored when enable=0 or load=1.
REQ-021 Wrap-around SHALL be modulo 2^N: all-ones + 1 = 0, and 0 - 1 = all-ones.
REQ-022 The FSM SHALL have three states: IDLE, CHECK and FAIL.
REQ-023 IDLE with arm=1: the monitor SHALL take expected <= f(counterN) at that edge and enter CHECK; no comparison is made in that cycle.
REQ-024 CHECK: on every edge the monitor SHALL compare counterN with expected and increment check_count.
REQ-025 CHECK on a match: expected <= f(expected), and the monitor SHALL stay in CHECK.
REQ-026 CHECK on a mismatch: the monitor SHALL enter FAIL, capture fail_observed, fail_expected and error_code, increment mismatch_count, and resync expected <= f(counterN).
REQ-027 FAIL: the monitor SHALL continue comparing with the same rules; each further mismatch increments mismatch_count and resyncs the model, but the capture registers and error_code SHALL NOT change.
REQ-028 The monitor SHALL register the command class of each edge for use by the following compare.
REQ-029 error_code SHALL be set from the preceding command: 3'b001 after a load, 3'b010 after an up-count, 3'b011 after a down-count, 3'b100 after a hold.
REQ-030 arm=0 in CHECK or FAIL SHALL return the monitor to IDLE on the next edge and clear pass, error, error_code, the counters and the capture registers; expected SHALL hold its value.
REQ-031 Re-arming SHALL restart the sequence at REQ-023.
REQ-032 pass SHALL equal (state==CHECK), and error SHALL equal (state==FAIL); both are registered-state decodes with no combinational path from the inputs.
REQ-033 The counters SHALL stop at 2^CW-1 and never wrap.

Reset
REQ-034 reset=0 at a rising edge SHALL force IDLE and zero every output (pass, error, error_code, expected, fail_observed, fail_expected, mismatch_count, check_count), taking priority over arm and all commands.
REQ-035 Reset asserted mid-CHECK or mid-FAIL SHALL take effect at that edge; after release, checking SHALL resume only through REQ-023.

Verification
REQ-036 The bench SHALL cover this scenario, N=8: arm=1, counterN=5, enable=1, dec=0, with the counter model correct for 10 cycles -> pass=1, error=0, check_count=10, mismatch_count=0.
REQ-037 The bench SHALL cover this scenario: load=1 with load_value=8'hC3 while the counter instead presents 8'hC2 on the next cycle -> error=1, error_code=3'b001, fail_observed=8'hC2, fail_expected=8'hC3.
REQ-038 The bench SHALL cover this scenario: expected=8'hFF with an up-count, counter shows 8'h00 -> no error; expected=8'h00 with a down-count, counter shows 8'hFF -> no error.
REQ-039 The bench SHALL cover this scenario: load=enable=dec=1, load_value=8'h10 -> expected=8'h10; then a hold with the counter drifting to 8'h11 -> error_code=3'b100, mismatch_count=1.
REQ-040 The bench SHALL cover this scenario: in FAIL with three further injected mismatches -> mismatch_count=4, while the capture registers and error_code keep their first-failure values.
REQ-041 The bench SHALL cover this scenario: reset=0 for one edge while in FAIL -> all outputs 0 and state IDLE; then arm=1 -> CHECK after one edge with pass=1.

Source files
------------

// File: rtl/counter_monitor.sv
// counter_monitor: watches the command inputs and the registered output of an
// up/down/load counter, predicts the counter's next value, and flags the
// first divergence between prediction and observation.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous active-low reset
//   arm            1 = check, 0 = return to IDLE and clear results
//   load/enable/dec/load_value   commands seen at the counter's input
//   counterN       registered counter output being monitored
//   pass           in CHECK (no mismatch since arming)
//   error          in FAIL (sticky until disarm/reset)
//   error_code     command class that preceded the first mismatch
//   expected       current predicted counter value
//   fail_observed  counterN captured at the first mismatch
//   fail_expected  prediction captured at the first mismatch
//   mismatch_count saturating count of mismatches since arming
//   check_count    saturating count of compare cycles since arming
module counter_monitor #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arm,
    input  logic          load,
    input  logic          enable,
    input  logic          dec,
    input  logic [N-1:0]  load_value,
    input  logic [N-1:0]  counterN,
    output logic          pass,
    output logic          error,
    output logic [2:0]    error_code,
    output logic [N-1:0]  expected,
    output logic [N-1:0]  fail_observed,
    output logic [N-1:0]  fail_expected,
    output logic [CW-1:0] mismatch_count,
    output logic [CW-1:0] check_count
);

    localparam int unsigned CODE_W = 3;

    localparam logic [CODE_W-1:0] CODE_NONE = 3'b000;
    localparam logic [CODE_W-1:0] CODE_LOAD = 3'b001;
    localparam logic [CODE_W-1:0] CODE_UP   = 3'b010;
    localparam logic [CODE_W-1:0] CODE_DOWN = 3'b011;
    localparam logic [CODE_W-1:0] CODE_HOLD = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FAIL  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [N-1:0]      expected_q, expected_d;
    logic [N-1:0]      fail_obs_q, fail_obs_d;
    logic [N-1:0]      fail_exp_q, fail_exp_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] cmd_q, cmd_d;
    logic [CW-1:0]     mis_q, mis_d;
    logic [CW-1:0]     chk_q, chk_d;

    logic [N-1:0]      next_from_counter_c;
    logic [N-1:0]      next_from_expected_c;
    logic [CODE_W-1:0] cmd_class_c;
    logic              mismatch_c;

    // Counter behaviour: load beats enable, enable beats hold, modulo 2^N.
    function automatic logic [N-1:0] model_next(
        input logic [N-1:0] v,
        input logic         ld,
        input logic         en,
        input logic         dn,
        input logic [N-1:0] lv
    );
        logic [N-1:0] r;
        if (ld) begin
            r = lv;
        end else if (en) begin
            r = dn ? (v - N'(1)) : (v + N'(1));
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : (c + CW'(1));
    endfunction

    // Prediction candidates and classification of this edge's command.
    always_comb begin
        next_from_counter_c  = model_next(counterN,   load, enable, dec, load_value);
        next_from_expected_c = model_next(expected_q, load, enable, dec, load_value);
        mismatch_c           = (counterN != expected_q);
        if (load) begin
            cmd_class_c = CODE_LOAD;
        end else if (enable) begin
            cmd_class_c = dec ? CODE_DOWN : CODE_UP;
        end else begin
            cmd_class_c = CODE_HOLD;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!arm) begin
                    state_d = S_IDLE;
                end else if (mismatch_c) begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (!arm) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the registered state.
    always_comb begin
        pass  = 1'b0;
        error = 1'b0;
        unique case (state_q)
            S_CHECK: pass  = 1'b1;
            S_FAIL:  error = 1'b1;
            default: begin
                pass  = 1'b0;
                error = 1'b0;
            end
        endcase
    end

    // Datapath next values: prediction, capture and counters.
    always_comb begin
        expected_d = expected_q;
        fail_obs_d = fail_obs_q;
        fail_exp_d = fail_exp_q;
        code_d     = code_q;
        mis_d      = mis_q;
        chk_d      = chk_q;
        cmd_d      = cmd_class_c;

        unique case (state_q)
            S_IDLE: begin
                // Arming seeds the model from the live counter; no compare yet.
                if (arm) begin
                    expected_d = next_from_counter_c;
                end
            end
            S_CHECK, S_FAIL: begin
                if (!arm) begin
                    // Results clear on disarm; the prediction is kept.
                    fail_obs_d = '0;
                    fail_exp_d = '0;
                    code_d     = CODE_NONE;
                    mis_d      = '0;
                    chk_d      = '0;
                end else begin
                    chk_d = sat_inc(chk_q);
                    if (mismatch_c) begin
                        mis_d      = sat_inc(mis_q);
                        expected_d = next_from_counter_c;
                        // Only the first mismatch since arming is captured.
                        if (state_q == S_CHECK) begin
                            fail_obs_d = counterN;
                            fail_exp_d = expected_q;
                            code_d     = cmd_q;
                        end
                    end else begin
                        expected_d = next_from_expected_c;
                    end
                end
            end
            default: begin
                expected_d = expected_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            expected_q <= '0;
            fail_obs_q <= '0;
            fail_exp_q <= '0;
            code_q     <= CODE_NONE;
            cmd_q      <= CODE_NONE;
            mis_q      <= '0;
            chk_q      <= '0;
        end else begin
            expected_q <= expected_d;
            fail_obs_q <= fail_obs_d;
            fail_exp_q <= fail_exp_d;
            code_q     <= code_d;
            cmd_q      <= cmd_d;
            mis_q      <= mis_d;
            chk_q      <= chk_d;
        end
    end

    assign error_code     = code_q;
    assign expected       = expected_q;
    assign fail_observed  = fail_obs_q;
    assign fail_expected  = fail_exp_q;
    assign mismatch_count = mis_q;
    assign check_count    = chk_q;

endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor: directed scenarios plus a randomized run of
// counter_monitor, with expectations from a behavioural reference model.
module tb_counter_monitor;

    localparam int unsigned TB_N  = 8;
    localparam int unsigned TB_CW = 6;
    localparam int          CMAX  = (1 << TB_CW) - 1;

    logic               clock;
    logic               reset;
    logic               arm;
    logic               load;
    logic               enable;
    logic               dec;
    logic [TB_N-1:0]    load_value;
    logic [TB_N-1:0]    counterN;
    logic               pass;
    logic               error;
    logic [2:0]         error_code;
    logic [TB_N-1:0]    expected;
    logic [TB_N-1:0]    fail_observed;
    logic [TB_N-1:0]    fail_expected;
    logic [TB_CW-1:0]   mismatch_count;
    logic [TB_CW-1:0]   check_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    bit          m_armed;
    bit          m_failed;
    logic [7:0]  m_exp;
    logic [7:0]  m_fobs;
    logic [7:0]  m_fexp;
    logic [2:0]  m_code;
    logic [2:0]  m_prev;
    int          m_mis;
    int          m_chk;

    counter_monitor #(.N(TB_N), .CW(TB_CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .arm            (arm),
        .load           (load),
        .enable         (enable),
        .dec            (dec),
        .load_value     (load_value),
        .counterN       (counterN),
        .pass           (pass),
        .error          (error),
        .error_code     (error_code),
        .expected       (expected),
        .fail_observed  (fail_observed),
        .fail_expected  (fail_expected),
        .mismatch_count (mismatch_count),
        .check_count    (check_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] ref_next(input logic [7:0] v, input logic ld,
                                            input logic en, input logic dn,
                                            input logic [7:0] lv);
        if (ld) return lv;
        if (en) return dn ? 8'(v - 8'd1) : 8'(v + 8'd1);
        return v;
    endfunction

    function automatic logic [2:0] ref_class(input logic ld, input logic en, input logic dn);
        if (ld) return 3'b001;
        if (en) return dn ? 3'b011 : 3'b010;
        return 3'b100;
    endfunction

    // Advance the reference model by one rising edge using the driven inputs.
    task automatic model_edge();
        if (!reset) begin
            m_armed = 0; m_failed = 0;
            m_exp = 0; m_fobs = 0; m_fexp = 0; m_code = 0;
            m_mis = 0; m_chk = 0;
        end else if (!m_armed) begin
            if (arm) begin
                m_armed = 1;
                m_exp   = ref_next(counterN, load, enable, dec, load_value);
            end
        end else if (!arm) begin
            m_armed = 0; m_failed = 0;
            m_fobs = 0; m_fexp = 0; m_code = 0;
            m_mis = 0; m_chk = 0;
        end else begin
            if (m_chk < CMAX) m_chk++;
            if (counterN == m_exp) begin
                m_exp = ref_next(m_exp, load, enable, dec, load_value);
            end else begin
                if (!m_failed) begin
                    m_failed = 1;
                    m_fobs   = counterN;
                    m_fexp   = m_exp;
                    m_code   = m_prev;
                end
                if (m_mis < CMAX) m_mis++;
                m_exp = ref_next(counterN, load, enable, dec, load_value);
            end
        end
        m_prev = ref_class(load, enable, dec);
    endtask

    // Drive one cycle of inputs, clock it, and sample 1ns after the edge.
    task automatic step(input logic a, input logic ld, input logic en, input logic dn,
                        input logic [7:0] lv, input logic [7:0] cnt);
        arm = a; load = ld; enable = en; dec = dn; load_value = lv; counterN = cnt;
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(0, 0, 0, 0, 8'h00, 8'h00);
        step(1, 1, 1, 0, 8'h55, 8'h12);
        n_checks++; if (pass !== 1'b0) $display("FAIL reset_pass got %0b want 0", pass); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL reset_error got %0b want 0", error); else n_pass++;
        n_checks++; if (expected !== 8'h00) $display("FAIL reset_expected got %0h want 0", expected); else n_pass++;
        n_checks++; if (check_count !== '0) $display("FAIL reset_check_count got %0d want 0", check_count); else n_pass++;
        n_checks++; if ({error_code, fail_observed, fail_expected, mismatch_count} !== '0)
            $display("FAIL reset_captures got %0h want 0", {error_code, fail_observed, fail_expected, mismatch_count});
        else n_pass++;
        reset = 1'b1;
        step(0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_count_up();
        step(1, 0, 1, 0, 8'h00, 8'h05);
        n_checks++; if (expected !== 8'h06) $display("FAIL arm_expected got %0h want 06", expected); else n_pass++;
        n_checks++; if (check_count !== '0) $display("FAIL arm_check_count got %0d want 0", check_count); else n_pass++;
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 8'h00, 8'(6 + i));
        n_checks++; if (pass !== 1'b1) $display("FAIL up_pass got %0b want 1", pass); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL up_error got %0b want 0", error); else n_pass++;
        n_checks++; if (check_count !== 6'd10) $display("FAIL up_check_count got %0d want 10", check_count); else n_pass++;
        n_checks++; if (mismatch_count !== '0) $display("FAIL up_mismatch_count got %0d want 0", mismatch_count); else n_pass++;
        n_checks++; if (expected !== 8'h10) $display("FAIL up_expected got %0h want 10", expected); else n_pass++;
        step(0, 0, 0, 0, 8'h00, 8'h10);
        n_checks++; if (pass !== 1'b0) $display("FAIL disarm_pass got %0b want 0", pass); else n_pass++;
        n_checks++; if (check_count !== '0) $display("FAIL disarm_check_count got %0d want 0", check_count); else n_pass++;
        n_checks++; if (expected !== 8'h10) $display("FAIL disarm_expected_hold got %0h want 10", expected); else n_pass++;
    endtask

    task automatic test_load_mismatch();
        step(1, 0, 0, 0, 8'h00, 8'h40);
        step(1, 1, 0, 0, 8'hC3, 8'h40);
        step(1, 0, 0, 0, 8'h00, 8'hC2);
        n_checks++; if (error !== 1'b1) $display("FAIL load_error got %0b want 1", error); else n_pass++;
        n_checks++; if (pass !== 1'b0) $display("FAIL load_pass got %0b want 0", pass); else n_pass++;
        n_checks++; if (error_code !== 3'b001) $display("FAIL load_code got %0b want 001", error_code); else n_pass++;
        n_checks++; if (fail_observed !== 8'hC2) $display("FAIL load_fail_observed got %0h want c2", fail_observed); else n_pass++;
        n_checks++; if (fail_expected !== 8'hC3) $display("FAIL load_fail_expected got %0h want c3", fail_expected); else n_pass++;
        step(0, 0, 0, 0, 8'h00, 8'hC2);
        n_checks++; if ({error, error_code, fail_observed, fail_expected, mismatch_count} !== '0)
            $display("FAIL disarm_clear got %0h want 0", {error, error_code, fail_observed, fail_expected, mismatch_count});
        else n_pass++;
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 0, 8'h00, 8'hFF);
        step(1, 0, 1, 0, 8'h00, 8'hFF);
        n_checks++; if (expected !== 8'h00) $display("FAIL wrap_up_expected got %0h want 00", expected); else n_pass++;
        step(1, 0, 1, 1, 8'h00, 8'h00);
        n_checks++; if (expected !== 8'hFF) $display("FAIL wrap_down_expected got %0h want ff", expected); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL wrap_up_error got %0b want 0", error); else n_pass++;
        step(1, 0, 0, 0, 8'h00, 8'hFF);
        n_checks++; if (error !== 1'b0) $display("FAIL wrap_down_error got %0b want 0", error); else n_pass++;
        n_checks++; if (check_count !== 6'd3) $display("FAIL wrap_check_count got %0d want 3", check_count); else n_pass++;
        step(0, 0, 0, 0, 8'h00, 8'hFF);
    endtask

    task automatic test_priority_hold();
        step(1, 0, 0, 0, 8'h00, 8'h20);
        step(1, 1, 1, 1, 8'h10, 8'h20);
        n_checks++; if (expected !== 8'h10) $display("FAIL prio_expected got %0h want 10", expected); else n_pass++;
        step(1, 0, 0, 0, 8'h00, 8'h10);
        step(1, 0, 0, 0, 8'h00, 8'h11);
        n_checks++; if (error_code !== 3'b100) $display("FAIL hold_code got %0b want 100", error_code); else n_pass++;
        n_checks++; if (mismatch_count !== 6'd1) $display("FAIL hold_mismatch_count got %0d want 1", mismatch_count); else n_pass++;
        n_checks++; if (error !== 1'b1) $display("FAIL hold_error got %0b want 1", error); else n_pass++;
    endtask

    // Continues from the FAIL state left by test_priority_hold.
    task automatic test_fail_sticky();
        step(1, 0, 1, 0, 8'h00, 8'h30);
        step(1, 0, 1, 1, 8'h00, 8'h50);
        step(1, 1, 0, 0, 8'h77, 8'h00);
        n_checks++; if (mismatch_count !== 6'd4) $display("FAIL sticky_mismatch_count got %0d want 4", mismatch_count); else n_pass++;
        n_checks++; if (error_code !== 3'b100) $display("FAIL sticky_code got %0b want 100", error_code); else n_pass++;
        n_checks++; if (fail_observed !== 8'h11) $display("FAIL sticky_fail_observed got %0h want 11", fail_observed); else n_pass++;
        n_checks++; if (fail_expected !== 8'h10) $display("FAIL sticky_fail_expected got %0h want 10", fail_expected); else n_pass++;
        n_checks++; if (expected !== 8'h77) $display("FAIL sticky_resync got %0h want 77", expected); else n_pass++;
        n_checks++; if (error !== 1'b1) $display("FAIL sticky_error got %0b want 1", error); else n_pass++;
    endtask

    task automatic test_reset_in_fail();
        reset = 1'b0;
        step(1, 1, 1, 0, 8'hAA, 8'h77);
        n_checks++; if ({pass, error, error_code, expected, fail_observed, fail_expected, mismatch_count, check_count} !== '0)
            $display("FAIL rst_fail_outputs got %0h want 0",
                     {pass, error, error_code, expected, fail_observed, fail_expected, mismatch_count, check_count});
        else n_pass++;
        reset = 1'b1;
        step(1, 0, 1, 0, 8'h00, 8'h05);
        n_checks++; if (pass !== 1'b1) $display("FAIL rearm_pass got %0b want 1", pass); else n_pass++;
        n_checks++; if (expected !== 8'h06) $display("FAIL rearm_expected got %0h want 06", expected); else n_pass++;
        n_checks++; if (check_count !== '0) $display("FAIL rearm_check_count got %0d want 0", check_count); else n_pass++;
        step(0, 0, 0, 0, 8'h00, 8'h06);
    endtask

    task automatic test_saturate();
        step(1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 70; i++) begin
            step(1, 0, 0, 0, 8'h00, 8'(i + 1));
            if (i == 61) begin
                n_checks++; if (mismatch_count !== 6'd62) $display("FAIL sat_pre_mismatch got %0d want 62", mismatch_count); else n_pass++;
            end
        end
        n_checks++; if (mismatch_count !== 6'd63) $display("FAIL sat_mismatch got %0d want 63", mismatch_count); else n_pass++;
        n_checks++; if (check_count !== 6'd63) $display("FAIL sat_check got %0d want 63", check_count); else n_pass++;
        step(0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] ctr;
        logic       a, ld, en, dn;
        logic [7:0] lv;
        ctr = 8'($urandom);
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            a     = ($urandom_range(0, 49) != 0);
            ld    = ($urandom_range(0, 99) < 15);
            en    = ($urandom_range(0, 99) < 60);
            dn    = 1'($urandom);
            lv    = 8'($urandom);
            if ($urandom_range(0, 19) == 0) ctr = 8'($urandom);
            step(a, ld, en, dn, lv, ctr);
            ctr = ref_next(ctr, ld, en, dn, lv);
            n_checks++; if (pass !== 1'(m_armed && !m_failed)) $display("FAIL rnd_pass cyc %0d got %0b want %0b", i, pass, m_armed && !m_failed); else n_pass++;
            n_checks++; if (error !== 1'(m_failed)) $display("FAIL rnd_error cyc %0d got %0b want %0b", i, error, m_failed); else n_pass++;
            n_checks++; if (error_code !== m_code) $display("FAIL rnd_code cyc %0d got %0b want %0b", i, error_code, m_code); else n_pass++;
            n_checks++; if (expected !== m_exp) $display("FAIL rnd_expected cyc %0d got %0h want %0h", i, expected, m_exp); else n_pass++;
            n_checks++; if (fail_observed !== m_fobs) $display("FAIL rnd_fail_observed cyc %0d got %0h want %0h", i, fail_observed, m_fobs); else n_pass++;
            n_checks++; if (fail_expected !== m_fexp) $display("FAIL rnd_fail_expected cyc %0d got %0h want %0h", i, fail_expected, m_fexp); else n_pass++;
            n_checks++; if (mismatch_count !== TB_CW'(m_mis)) $display("FAIL rnd_mismatch_count cyc %0d got %0d want %0d", i, mismatch_count, m_mis); else n_pass++;
            n_checks++; if (check_count !== TB_CW'(m_chk)) $display("FAIL rnd_check_count cyc %0d got %0d want %0d", i, check_count, m_chk); else n_pass++;
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; arm = 0; load = 0; enable = 0; dec = 0;
        load_value = 0; counterN = 0;
        m_armed = 0; m_failed = 0; m_exp = 0; m_fobs = 0; m_fexp = 0;
        m_code = 0; m_prev = 0; m_mis = 0; m_chk = 0;
        test_reset();
        test_count_up();
        test_load_mismatch();
        test_wrap();
        test_priority_hold();
        test_fail_sticky();
        test_reset_in_fail();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
